// File: rtl/reservation_station_mp.sv
// reservation_station_mp: partitioned ALU reservation station. Entries wait
// for operands (issue-time forwarding + CDB wakeup), then dispatch per port.
// Ports: clk_in/rst_n_in (async low), rdy_in stall, clear_signal flush,
// issue_* valid/ready intake, alu_* per-port valid/ready dispatch (flattened),
// cdb_* wakeup buses (flattened), full, count (busy entries).
// Optional macro RS_OLDEST_FIRST_EN: age matrix, oldest-eligible selection.
module reservation_station_mp #(
  parameter int RS_WIDTH  = 4,
  parameter int ROB_WIDTH = 4,
  parameter int NUM_ALU   = 2,
  parameter int NUM_CDB   = 3
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         clear_signal,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [3:0]                   issue_opcode,
  input  logic [31:0]                  issue_val1,
  input  logic [31:0]                  issue_val2,
  input  logic [ROB_WIDTH-1:0]         issue_tag1,
  input  logic [ROB_WIDTH-1:0]         issue_tag2,
  input  logic                         issue_rdy1,
  input  logic                         issue_rdy2,
  input  logic [ROB_WIDTH-1:0]         issue_rd_tag,
  output logic [NUM_ALU-1:0]           alu_valid,
  input  logic [NUM_ALU-1:0]           alu_ready,
  output logic [4*NUM_ALU-1:0]         alu_opcode,
  output logic [32*NUM_ALU-1:0]        alu_lhs,
  output logic [32*NUM_ALU-1:0]        alu_rhs,
  output logic [ROB_WIDTH*NUM_ALU-1:0] alu_rd_tag,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [32*NUM_CDB-1:0]        cdb_value,
  input  logic [ROB_WIDTH*NUM_CDB-1:0] cdb_tag,
  output logic                         full,
  output logic [RS_WIDTH:0]            count
);

  localparam int RS_SIZE = 2 ** RS_WIDTH;
  localparam int PART    = RS_SIZE / NUM_ALU;

  logic [RS_SIZE-1:0]   busy, rdy1, rdy2;
  logic [RS_SIZE-1:0]   busy_n, rdy1_n, rdy2_n;
  logic [3:0]           opc  [RS_SIZE];
  logic [31:0]          val1 [RS_SIZE];
  logic [31:0]          val2 [RS_SIZE];
  logic [ROB_WIDTH-1:0] tag1 [RS_SIZE];
  logic [ROB_WIDTH-1:0] tag2 [RS_SIZE];
  logic [ROB_WIDTH-1:0] rdt  [RS_SIZE];

  logic [RS_SIZE-1:0]   elig, older, disp;
  logic [RS_SIZE-1:0]   wk1, wk2;
  logic [32:0]          hit1 [RS_SIZE];
  logic [32:0]          hit2 [RS_SIZE];
  logic [32:0]          fwd1, fwd2;
  logic [RS_WIDTH-1:0]  free_idx;
  logic                 accept;

  logic [NUM_ALU-1:0]   sel_found, hs, lock_v;
  logic [RS_WIDTH-1:0]  sel_idx  [NUM_ALU];
  logic [RS_WIDTH-1:0]  lock_idx [NUM_ALU];

  // {hit, value}; lowest-numbered matching bus wins
  function automatic logic [32:0] snoop(
    input logic [ROB_WIDTH-1:0]         t,
    input logic [NUM_CDB-1:0]           v,
    input logic [32*NUM_CDB-1:0]        d,
    input logic [ROB_WIDTH*NUM_CDB-1:0] g
  );
    logic [32:0] r;
    r = '0;
    for (int j = NUM_CDB - 1; j >= 0; j--)
      if (v[j] && g[j*ROB_WIDTH +: ROB_WIDTH] == t)
        r = {1'b1, d[j*32 +: 32]};
    return r;
  endfunction

  assign elig        = busy & rdy1 & rdy2;
  assign full        = &busy;
  assign issue_ready = ~full;
  assign accept      = issue_valid & issue_ready
                     & rdy_in & ~clear_signal;
  assign alu_valid   = sel_found & {NUM_ALU{rdy_in}};
  assign hs          = alu_valid & alu_ready;

  always_comb begin
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!busy[i]) free_idx = RS_WIDTH'(i);
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < RS_SIZE; i++)
      count = count + (RS_WIDTH+1)'(busy[i]);
  end

  always_comb begin
    fwd1 = snoop(issue_tag1, cdb_valid, cdb_value, cdb_tag);
    fwd2 = snoop(issue_tag2, cdb_valid, cdb_value, cdb_tag);
    for (int i = 0; i < RS_SIZE; i++) begin
      hit1[i] = snoop(tag1[i], cdb_valid, cdb_value, cdb_tag);
      hit2[i] = snoop(tag2[i], cdb_valid, cdb_value, cdb_tag);
      wk1[i]  = busy[i] & ~rdy1[i] & hit1[i][32];
      wk2[i]  = busy[i] & ~rdy2[i] & hit2[i][32];
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // age[i][j] set: entry j is older than entry i
  logic [RS_SIZE-1:0] age   [RS_SIZE];
  logic [RS_SIZE-1:0] age_n [RS_SIZE];

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      older[i] = 1'b0;
      for (int j = 0; j < RS_SIZE; j++)
        if ((j % NUM_ALU) == (i % NUM_ALU)
            && age[i][j] && elig[j])
          older[i] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      age_n[i] = disp[i] ? '0 : (age[i] & ~disp);
    if (accept) begin
      for (int i = 0; i < RS_SIZE; i++)
        age_n[i][free_idx] = 1'b0;
      age_n[free_idx] = busy & ~disp;
    end
    if (clear_signal)
      for (int i = 0; i < RS_SIZE; i++)
        age_n[i] = '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RS_SIZE; i++)
        age[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++)
        age[i] <= age_n[i];
    end
  end
`else
  assign older = '0;
`endif

  // A presented-but-stalled entry is locked so the port keeps it
  // even if another entry in the partition becomes preferable.
  always_comb begin
    for (int k = 0; k < NUM_ALU; k++) begin
      sel_found[k] = 1'b0;
      sel_idx[k]   = RS_WIDTH'(k);
      for (int m = PART - 1; m >= 0; m--)
        if (elig[m*NUM_ALU+k] && !older[m*NUM_ALU+k]) begin
          sel_found[k] = 1'b1;
          sel_idx[k]   = RS_WIDTH'(m*NUM_ALU+k);
        end
      if (lock_v[k]) begin
        sel_found[k] = 1'b1;
        sel_idx[k]   = lock_idx[k];
      end
    end
  end

  always_comb begin
    disp = '0;
    for (int k = 0; k < NUM_ALU; k++)
      if (hs[k]) disp[sel_idx[k]] = 1'b1;
  end

  always_comb begin
    for (int k = 0; k < NUM_ALU; k++) begin
      alu_opcode[4*k +: 4]  = opc[sel_idx[k]];
      alu_lhs[32*k +: 32]   = val1[sel_idx[k]];
      alu_rhs[32*k +: 32]   = val2[sel_idx[k]];
      alu_rd_tag[ROB_WIDTH*k +: ROB_WIDTH] = rdt[sel_idx[k]];
    end
  end

  always_comb begin
    busy_n = busy & ~disp;
    rdy1_n = (rdy1 | wk1) & ~disp;
    rdy2_n = (rdy2 | wk2) & ~disp;
    if (accept) begin
      busy_n[free_idx] = 1'b1;
      rdy1_n[free_idx] = issue_rdy1 | fwd1[32];
      rdy2_n[free_idx] = issue_rdy2 | fwd2[32];
    end
    if (clear_signal) begin
      busy_n = '0;
      rdy1_n = '0;
      rdy2_n = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy   <= '0;
      rdy1   <= '0;
      rdy2   <= '0;
      lock_v <= '0;
      for (int k = 0; k < NUM_ALU; k++)
        lock_idx[k] <= '0;
    end else if (rdy_in) begin
      busy <= busy_n;
      rdy1 <= rdy1_n;
      rdy2 <= rdy2_n;
      for (int k = 0; k < NUM_ALU; k++) begin
        if (clear_signal || hs[k]) begin
          lock_v[k] <= 1'b0;
        end else if (alu_valid[k]) begin
          lock_v[k]   <= 1'b1;
          lock_idx[k] <= sel_idx[k];
        end
      end
    end
  end

  // payload carries no reset
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_signal) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (wk1[i]) val1[i] <= hit1[i][31:0];
        if (wk2[i]) val2[i] <= hit2[i][31:0];
      end
      if (accept) begin
        opc[free_idx]  <= issue_opcode;
        tag1[free_idx] <= issue_tag1;
        tag2[free_idx] <= issue_tag2;
        rdt[free_idx]  <= issue_rd_tag;
        val1[free_idx] <= issue_rdy1 ? issue_val1 : fwd1[31:0];
        val2[free_idx] <= issue_rdy2 ? issue_val2 : fwd2[31:0];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_mp.sv
// tb_reservation_station_mp: scenario tasks with a dispatch scoreboard
// for reservation_station_mp (default parameters).
module tb_reservation_station_mp;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_signal;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_opcode;
  logic [31:0] issue_val1, issue_val2;
  logic [3:0]  issue_tag1, issue_tag2;
  logic        issue_rdy1, issue_rdy2;
  logic [3:0]  issue_rd_tag;
  logic [1:0]  alu_valid;
  logic [1:0]  alu_ready;
  logic [7:0]  alu_opcode;
  logic [63:0] alu_lhs, alu_rhs;
  logic [7:0]  alu_rd_tag;
  logic [2:0]  cdb_valid;
  logic [95:0] cdb_value;
  logic [11:0] cdb_tag;
  logic        full;
  logic [4:0]  count;

  reservation_station_mp dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .clear_signal(clear_signal),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode),
    .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
    .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
    .issue_rd_tag(issue_rd_tag),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_opcode(alu_opcode), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
    .alu_rd_tag(alu_rd_tag),
    .cdb_valid(cdb_valid), .cdb_value(cdb_value), .cdb_tag(cdb_tag),
    .full(full), .count(count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  rd;
  } disp_t;

  disp_t sb[$];
  disp_t exp_d;
  int checks = 0;
  int errors = 0;

  function automatic disp_t port_out(input int k);
    return {alu_opcode[4*k +: 4], alu_lhs[32*k +: 32],
            alu_rhs[32*k +: 32], alu_rd_tag[4*k +: 4]};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue_one(
    input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
    input logic [3:0] t1, input logic [3:0] t2,
    input logic r1, input logic r2, input logic [3:0] rd
  );
    issue_valid  = 1'b1;
    issue_opcode = op;
    issue_val1   = v1;
    issue_val2   = v2;
    issue_tag1   = t1;
    issue_tag2   = t2;
    issue_rdy1   = r1;
    issue_rdy2   = r2;
    issue_rd_tag = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic set_cdb(input int j, input logic [3:0] t,
                         input logic [31:0] v);
    cdb_valid[j]        = 1'b1;
    cdb_tag[4*j +: 4]   = t;
    cdb_value[32*j +: 32] = v;
  endtask

  task automatic pulse_clear();
    clear_signal = 1'b1;
    tick();
    clear_signal = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_signal = 1'b0;
    issue_valid = 1'b0; issue_opcode = '0;
    issue_val1 = '0; issue_val2 = '0; issue_tag1 = '0; issue_tag2 = '0;
    issue_rdy1 = 1'b0; issue_rdy2 = 1'b0; issue_rd_tag = '0;
    alu_ready = '0; cdb_valid = '0; cdb_value = '0; cdb_tag = '0;
    #1;
    checks++;
    if (count !== 5'd0 || alu_valid !== 2'b00 || full !== 1'b0
        || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: count=%0d valid=%b full=%b rdy=%b want 0 00 0 1",
               count, alu_valid, full, issue_ready);
    end
    tick(); tick();
    rst_n_in = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++)
      issue_one(4'd1, 32'd0, 32'd0, 4'(i), 4'd0, 1'b0, 1'b1, 4'(i));
    issue_one(4'd1, 32'd9, 32'd9, 4'd0, 4'd0, 1'b1, 1'b1, 4'd5);
    checks++;
    if (count !== 5'd5 || alu_valid !== 2'b01) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d valid=%b want 5 01",
               count, alu_valid);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || alu_valid !== 2'b00 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count=%0d valid=%b full=%b want 0 00 0",
               count, alu_valid, full);
    end
    tick();
    rst_n_in = 1'b1;
    alu_ready = 2'b01;
    sb.push_back({4'd0, 32'd3, 32'd4, 4'd1});
    issue_one(4'd0, 32'd3, 32'd4, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
    exp_d = sb.pop_front();
    checks++;
    if (alu_valid[0] !== 1'b1 || port_out(0) !== exp_d) begin
      errors++;
      $display("FAIL reset_add: valid=%b got %h want %h",
               alu_valid, port_out(0), exp_d);
    end
    tick();
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL reset_add_free: count=%0d want 0", count);
    end
  endtask

  task automatic test_forward();
    alu_ready = 2'b11;
    set_cdb(1, 4'd5, 32'h55);
    set_cdb(2, 4'd5, 32'h99);
    sb.push_back({4'd2, 32'h55, 32'd7, 4'd3});
    issue_one(4'd2, 32'hdead, 32'd7, 4'd5, 4'd0, 1'b0, 1'b1, 4'd3);
    cdb_valid = '0;
    exp_d = sb.pop_front();
    checks++;
    if (alu_valid !== 2'b01 || port_out(0) !== exp_d) begin
      errors++;
      $display("FAIL fwd_dispatch: valid=%b got %h want %h",
               alu_valid, port_out(0), exp_d);
    end
    tick();
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL fwd_free: count=%0d want 0", count);
    end
  endtask

  task automatic test_wakeup();
    alu_ready = 2'b11;
    issue_one(4'd3, 32'd0, 32'd1, 4'd7, 4'd0, 1'b0, 1'b1, 4'd4);
    checks++;
    if (alu_valid !== 2'b00) begin
      errors++;
      $display("FAIL wake_waiting: valid=%b want 00", alu_valid);
    end
    set_cdb(0, 4'd7, 32'h77);
    set_cdb(2, 4'd7, 32'hee);
    sb.push_back({4'd3, 32'h77, 32'd1, 4'd4});
    #1;
    checks++;
    if (alu_valid !== 2'b00) begin
      errors++;
      $display("FAIL wake_same_cycle: valid=%b want 00", alu_valid);
    end
    tick();
    cdb_valid = '0;
    exp_d = sb.pop_front();
    checks++;
    if (alu_valid !== 2'b01 || port_out(0) !== exp_d) begin
      errors++;
      $display("FAIL wake_dispatch: valid=%b got %h want %h",
               alu_valid, port_out(0), exp_d);
    end
    tick();
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL wake_free: count=%0d want 0", count);
    end
  endtask

  task automatic test_back_pressure();
    alu_ready = 2'b00;
    issue_one(4'd1, 32'd0, 32'd0, 4'd15, 4'd0, 1'b0, 1'b1, 4'd0);
    sb.push_back({4'd5, 32'h11, 32'h22, 4'd6});
    issue_one(4'd5, 32'h11, 32'h22, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (alu_valid[1] !== 1'b1 || port_out(1) !== sb[0]) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b got %h want %h",
                 c, alu_valid, port_out(1), sb[0]);
      end
      if (c < 2) tick();
    end
    checks++;
    if (count !== 5'd2) begin
      errors++;
      $display("FAIL bp_count_before: count=%0d want 2", count);
    end
    alu_ready = 2'b10;
    exp_d = sb.pop_front();
    tick();
    alu_ready = 2'b00;
    checks++;
    if (count !== 5'd1 || alu_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: count=%0d valid=%b want 1 0x",
               count, alu_valid);
    end
    pulse_clear();
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL bp_clear: count=%0d want 0", count);
    end
  endtask

  task automatic test_full();
    alu_ready = 2'b00;
    for (int i = 0; i < 16; i++)
      issue_one(4'd7, 32'd0, 32'(i), 4'(i), 4'd0, 1'b0, 1'b1, 4'(i));
    checks++;
    if (full !== 1'b1 || issue_ready !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_state: full=%b rdy=%b count=%0d want 1 0 16",
               full, issue_ready, count);
    end
    issue_one(4'd9, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd0);
    checks++;
    if (count !== 5'd16 || alu_valid !== 2'b00) begin
      errors++;
      $display("FAIL full_ignore: count=%0d valid=%b want 16 00",
               count, alu_valid);
    end
    alu_ready = 2'b11;
    set_cdb(0, 4'd6, 32'h66);
    sb.push_back({4'd7, 32'h66, 32'd6, 4'd6});
    tick();
    cdb_valid = '0;
    exp_d = sb.pop_front();
    checks++;
    if (alu_valid !== 2'b01 || port_out(0) !== exp_d || full !== 1'b1) begin
      errors++;
      $display("FAIL full_wake: valid=%b full=%b got %h want %h",
               alu_valid, full, port_out(0), exp_d);
    end
    tick();
    checks++;
    if (full !== 1'b0 || count !== 5'd15 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_release: full=%b count=%0d rdy=%b want 0 15 1",
               full, count, issue_ready);
    end
  endtask

  task automatic test_clear();
    alu_ready = 2'b00;
    pulse_clear();
    issue_one(4'd8, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 4'd1);
    for (int i = 1; i <= 8; i++)
      issue_one(4'd1, 32'd0, 32'd0, 4'(i), 4'd0, 1'b0, 1'b1, 4'(i));
    checks++;
    if (count !== 5'd9 || alu_valid !== 2'b01) begin
      errors++;
      $display("FAIL clear_prefill: count=%0d valid=%b want 9 01",
               count, alu_valid);
    end
    clear_signal = 1'b1;
    alu_ready = 2'b11;
    issue_one(4'd9, 32'd5, 32'd5, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9);
    clear_signal = 1'b0;
    checks++;
    if (count !== 5'd0 || alu_valid !== 2'b00 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush: count=%0d valid=%b full=%b want 0 00 0",
               count, alu_valid, full);
    end
    tick();
    checks++;
    if (alu_valid !== 2'b00 || count !== 5'd0) begin
      errors++;
      $display("FAIL clear_no_ghost: valid=%b count=%0d want 00 0",
               alu_valid, count);
    end
  endtask

  task automatic test_oldest();
    alu_ready = 2'b11;
    issue_one(4'd1, 32'd0, 32'd0, 4'd1, 4'd0, 1'b0, 1'b1, 4'd10);
    issue_one(4'd1, 32'd0, 32'd0, 4'd1, 4'd0, 1'b0, 1'b1, 4'd11);
    issue_one(4'd2, 32'd0, 32'd2, 4'd9, 4'd0, 1'b0, 1'b1, 4'd12);
    set_cdb(0, 4'd1, 32'h10);
    sb.push_back({4'd1, 32'h10, 32'd0, 4'd10});
    sb.push_back({4'd1, 32'h10, 32'd0, 4'd11});
    tick();
    cdb_valid = '0;
    exp_d = sb.pop_front();
    checks++;
    if (alu_valid[0] !== 1'b1 || port_out(0) !== exp_d) begin
      errors++;
      $display("FAIL old_x: valid=%b got %h want %h",
               alu_valid, port_out(0), exp_d);
    end
    exp_d = sb.pop_front();
    checks++;
    if (alu_valid[1] !== 1'b1 || port_out(1) !== exp_d) begin
      errors++;
      $display("FAIL old_y: valid=%b got %h want %h",
               alu_valid, port_out(1), exp_d);
    end
    tick();
    issue_one(4'd3, 32'd0, 32'd3, 4'd9, 4'd0, 1'b0, 1'b1, 4'd13);
    set_cdb(2, 4'd9, 32'h90);
`ifdef RS_OLDEST_FIRST_EN
    sb.push_back({4'd2, 32'h90, 32'd2, 4'd12});
    sb.push_back({4'd3, 32'h90, 32'd3, 4'd13});
`else
    sb.push_back({4'd3, 32'h90, 32'd3, 4'd13});
    sb.push_back({4'd2, 32'h90, 32'd2, 4'd12});
`endif
    tick();
    cdb_valid = '0;
    for (int n = 0; n < 2; n++) begin
      exp_d = sb.pop_front();
      checks++;
      if (alu_valid !== 2'b01 || port_out(0) !== exp_d) begin
        errors++;
        $display("FAIL old_order%0d: valid=%b got %h want %h",
                 n, alu_valid, port_out(0), exp_d);
      end
      tick();
    end
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL old_free: count=%0d want 0", count);
    end
  endtask

  task automatic test_back_to_back();
    alu_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      sb.push_back({4'(i), 32'(i * 3), 32'(i + 100), 4'(i)});
      issue_one(4'(i), 32'(i * 3), 32'(i + 100),
                4'd0, 4'd0, 1'b1, 1'b1, 4'(i));
      exp_d = sb.pop_front();
      checks++;
      if (count !== 5'd1
          || alu_valid !== ((i % 2 == 0) ? 2'b01 : 2'b10)
          || port_out(i % 2) !== exp_d) begin
        errors++;
        $display("FAIL b2b%0d: count=%0d valid=%b got %h want %h",
                 i, count, alu_valid, port_out(i % 2), exp_d);
      end
    end
    tick();
    checks++;
    if (count !== 5'd0 || alu_valid !== 2'b00) begin
      errors++;
      $display("FAIL b2b_drain: count=%0d valid=%b want 0 00",
               count, alu_valid);
    end
  endtask

  task automatic test_stall();
    alu_ready = 2'b00;
    issue_one(4'd6, 32'h5, 32'h6, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9);
    rdy_in = 1'b0;
    #1;
    checks++;
    if (alu_valid !== 2'b00) begin
      errors++;
      $display("FAIL stall_valid: valid=%b want 00", alu_valid);
    end
    alu_ready = 2'b11;
    issue_one(4'd4, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2);
    checks++;
    if (count !== 5'd1) begin
      errors++;
      $display("FAIL stall_hold: count=%0d want 1", count);
    end
    rdy_in = 1'b1;
    sb.push_back({4'd6, 32'h5, 32'h6, 4'd9});
    #1;
    exp_d = sb.pop_front();
    checks++;
    if (alu_valid !== 2'b01 || port_out(0) !== exp_d) begin
      errors++;
      $display("FAIL stall_resume: valid=%b got %h want %h",
               alu_valid, port_out(0), exp_d);
    end
    tick();
    checks++;
    if (count !== 5'd0) begin
      errors++;
      $display("FAIL stall_free: count=%0d want 0", count);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_wakeup();
    test_back_pressure();
    test_full();
    test_clear();
    test_oldest();
    test_back_to_back();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
